// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment patterns, enable
// codes and the slot phase type used by the scan controller and by the
// single-digit counter blocks that reuse the decoder.
package seg7_pkg;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for 0-9, dp bit left dark.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'b11000000,
    8'b11111001,
    8'b10100100,
    8'b10110000,
    8'b10011001,
    8'b10010010,
    8'b10000010,
    8'b11111000,
    8'b10000000,
    8'b10010000
  };

  // Out-of-range BCD values show only the g segment.
  localparam logic [7:0] SEG_DASH = 8'b10111111;

  // Every segment dark, including the decimal point.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // No digit selected.
  localparam logic [3:0] EN_NONE = 4'b1111;

  // Phase inside one digit slot.
  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_e;

  // Active-low one-cold enable for the given slot index.
  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << idx;
    return ~oneHot;
  endfunction

endpackage

// File: rtl/bcd_to_seven_segment.sv
// Combinational BCD to active-low seven-segment decoder with decimal point
// and blank control. A blanked digit keeps its decimal point so that a
// suppressed leading zero can still carry a lit dp.
module bcd_to_seven_segment
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] pattern;

  // Look up the glyph; anything above 9 becomes a dash.
  always_comb begin
    pattern = SEG_DASH;
    case (bcd)
      4'd0:    pattern = SEG_DIGIT[0];
      4'd1:    pattern = SEG_DIGIT[1];
      4'd2:    pattern = SEG_DIGIT[2];
      4'd3:    pattern = SEG_DIGIT[3];
      4'd4:    pattern = SEG_DIGIT[4];
      4'd5:    pattern = SEG_DIGIT[5];
      4'd6:    pattern = SEG_DIGIT[6];
      4'd7:    pattern = SEG_DIGIT[7];
      4'd8:    pattern = SEG_DIGIT[8];
      4'd9:    pattern = SEG_DIGIT[9];
      default: pattern = SEG_DASH;
    endcase
  end

  // Blank the glyph segments if asked, then overlay the active-low dp.
  always_comb begin
    seg    = blank ? SEG_OFF : pattern;
    seg[7] = ~dp;
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Four-digit multiplexed seven-segment scanner. Each digit owns a slot of
// REFRESH_DIV clocks that starts with BLANK_CYCLES clocks of all enables
// off to stop ghosting. Inputs are captured into shadow registers once per
// frame so a frame never mixes old and new digits. All pins are registered
// from the scan state, one clock behind it.
module seven_segment_scan_controller
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_bcd,
  input  logic [3:0]  dp_mask,
  input  logic        blank_leading_zero,
  output logic [7:0]  seven_segment_data,
  output logic [3:0]  seven_segment_enable,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadowDigits_q;
  logic [3:0]       shadowDp_q;
  logic             shadowBlz_q;
  logic [7:0]       segData_q, segData_d;
  logic [3:0]       segEnable_q, segEnable_d;
  logic             frameDone_q, frameDone_d;

  logic             slotEnd;
  logic             frameWrap;
  logic [3:0]       curDigit;
  logic             curDp;
  logic [3:0]       suppress;
  logic             curSuppress;
  logic [7:0]       decSeg;
  phase_e           phase;

  // Slot and frame boundaries derived from the dwell counter and index.
  always_comb begin
    slotEnd   = (cnt_q == CNT_MAX);
    frameWrap = slotEnd && (idx_q == 2'd3);
  end

  // Dwell counter runs every clock; the slot index steps at each slot end.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slotEnd) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Blank phase covers the first BLANK_CYCLES clocks of each slot.
  always_comb begin
    phase = (cnt_q < BLANK_END) ? PH_BLANK : PH_SHOW;
  end

  // Pick the shadowed digit and decimal point for the current slot.
  always_comb begin
    curDigit = shadowDigits_q[{idx_q, 2'b00} +: 4];
    curDp    = shadowDp_q[idx_q];
  end

  // Leading zeros are suppressed from the left until a nonzero digit;
  // the rightmost digit always shows.
  always_comb begin
    suppress    = 4'b0000;
    suppress[3] = shadowBlz_q && (shadowDigits_q[15:12] == 4'd0);
    suppress[2] = suppress[3] && (shadowDigits_q[11:8] == 4'd0);
    suppress[1] = suppress[2] && (shadowDigits_q[7:4] == 4'd0);
    curSuppress = suppress[idx_q];
  end

  bcd_to_seven_segment u_decoder (
    .bcd   (curDigit),
    .dp    (curDp),
    .blank (curSuppress),
    .seg   (decSeg)
  );

  // Next pin values: dark during the blank phase or for a suppressed digit
  // without a dp, otherwise enable the slot's digit with its decoded glyph.
  always_comb begin
    segEnable_d = EN_NONE;
    segData_d   = SEG_OFF;
    frameDone_d = frameWrap;
    if (phase == PH_SHOW) begin
      if (!(curSuppress && !curDp)) begin
        segEnable_d = digit_enable(idx_q);
        segData_d   = decSeg;
      end
    end
  end

  // Scan state: counter and slot index restart from slot 0 on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Shadow registers reload only at the frame wrap so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadowDigits_q <= 16'h0000;
      shadowDp_q     <= 4'b0000;
      shadowBlz_q    <= 1'b0;
    end else if (frameWrap) begin
      shadowDigits_q <= digits_bcd;
      shadowDp_q     <= dp_mask;
      shadowBlz_q    <= blank_leading_zero;
    end
  end

  // Output registers: pins follow the scan state one clock later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      segEnable_q <= EN_NONE;
      segData_q   <= SEG_OFF;
      frameDone_q <= 1'b0;
    end else begin
      segEnable_q <= segEnable_d;
      segData_q   <= segData_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign seven_segment_data   = segData_q;
  assign seven_segment_enable = segEnable_q;
  assign frame_done           = frameDone_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for the seven-segment scanner with a short slot
// (8 clocks, 2 of them blank) so a frame is 32 clocks.
module tb_seven_segment_scan_controller;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  localparam logic [3:0] SLOT_EN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk;
  logic        reset;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_mask;
  logic        blank_leading_zero;
  logic [7:0]  seven_segment_data;
  logic [3:0]  seven_segment_enable;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  logic [3:0] capEn   [FRAME];
  logic [7:0] capData [FRAME];
  logic       capFd   [FRAME];

  seven_segment_scan_controller #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .digits_bcd           (digits_bcd),
    .dp_mask              (dp_mask),
    .blank_leading_zero   (blank_leading_zero),
    .seven_segment_data   (seven_segment_data),
    .seven_segment_enable (seven_segment_enable),
    .frame_done           (frame_done)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the scan never produces frame strobes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic blz);
    digits_bcd         = d;
    dp_mask            = dp;
    blank_leading_zero = blz;
  endtask

  // Hold reset five clocks, release, then follow the reset-shadow frame
  // (all "0", no dp) up to the first frame strobe.
  task automatic runResetFrame(input string tag);
    int latency;
    int slot;
    int pos;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_hold%0d_en", tag, i), {4'b0, seven_segment_enable}, 8'h0F);
      checkOutput($sformatf("%s_hold%0d_data", tag, i), seven_segment_data, 8'hFF);
      checkOutput($sformatf("%s_hold%0d_fd", tag, i), {7'b0, frame_done}, 8'h00);
    end
    reset   = 1'b0;
    latency = 0;
    for (int k = 1; k <= FRAME + 8; k++) begin
      @(negedge clk);
      slot = ((k - 1) / RD) & 3;
      pos  = (k - 1) % RD;
      if (pos < BC) begin
        checkOutput($sformatf("%s_k%0d_en", tag, k), {4'b0, seven_segment_enable}, 8'h0F);
        checkOutput($sformatf("%s_k%0d_data", tag, k), seven_segment_data, 8'hFF);
      end else begin
        checkOutput($sformatf("%s_k%0d_en", tag, k), {4'b0, seven_segment_enable}, {4'b0, SLOT_EN[slot]});
        checkOutput($sformatf("%s_k%0d_data", tag, k), seven_segment_data, 8'hC0);
      end
      if (frame_done) begin
        latency = k;
        break;
      end
    end
    checkOutput($sformatf("%s_fdLatency", tag), 8'(latency), 8'(FRAME));
  endtask

  task automatic waitFrameDone(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("%s_waitFd", tag), {7'b0, found}, 8'h01);
  endtask

  // Record the 32 cycles following a frame strobe; optionally change the
  // digit inputs partway through.
  task automatic captureFrame(input int changeIdx, input logic [15:0] changeVal);
    for (int i = 0; i < FRAME; i++) begin
      if (i == changeIdx) digits_bcd = changeVal;
      @(negedge clk);
      capEn[i]   = seven_segment_enable;
      capData[i] = seven_segment_data;
      capFd[i]   = frame_done;
    end
  endtask

  // enExp/dataExp hold the show-phase values per slot, slot 0 in the low bits.
  task automatic checkFrame(input string tag, input logic [15:0] enExp, input logic [31:0] dataExp);
    int s;
    int p;
    for (int i = 0; i < FRAME; i++) begin
      s = i / RD;
      p = i % RD;
      if (p < BC) begin
        checkOutput($sformatf("%s_s%0dp%0d_en", tag, s, p), {4'b0, capEn[i]}, 8'h0F);
        checkOutput($sformatf("%s_s%0dp%0d_data", tag, s, p), capData[i], 8'hFF);
      end else begin
        checkOutput($sformatf("%s_s%0dp%0d_en", tag, s, p), {4'b0, capEn[i]}, {4'b0, enExp[s*4 +: 4]});
        checkOutput($sformatf("%s_s%0dp%0d_data", tag, s, p), capData[i], dataExp[s*8 +: 8]);
      end
      checkOutput($sformatf("%s_i%0d_fd", tag, i), {7'b0, capFd[i]}, (i == FRAME - 1) ? 8'h01 : 8'h00);
    end
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b1;
    applyStimulus(16'h0000, 4'b0000, 1'b0);

    // Reset frame shows 0000 even though 1234 is already on the inputs.
    applyStimulus(16'h1234, 4'b0000, 1'b0);
    runResetFrame("rst0");
    captureFrame(-1, 16'h0000);
    checkFrame("h1234", 16'h7BDE, 32'hF9A4B099);

    // Leading zeros blanked on digits 3 and 2.
    applyStimulus(16'h0050, 4'b0000, 1'b1);
    waitFrameDone("h0050");
    captureFrame(-1, 16'h0000);
    checkFrame("h0050", 16'hFFDE, 32'hFFFF92C0);

    // Dash with dp on digit 1.
    applyStimulus(16'h00A0, 4'b0010, 1'b0);
    waitFrameDone("h00A0");
    captureFrame(-1, 16'h0000);
    checkFrame("h00A0", 16'h7BDE, 32'hC0C03FC0);

    // Suppressed digit 3 keeps its dp; digits 2 and 1 fully blank.
    applyStimulus(16'h0005, 4'b1000, 1'b1);
    waitFrameDone("h0005");
    captureFrame(-1, 16'h0000);
    checkFrame("h0005", 16'h7FFE, 32'h7FFFFF92);

    // Nonzero dash on digit 2 stops suppression below it.
    applyStimulus(16'h0F00, 4'b0000, 1'b1);
    waitFrameDone("h0F00");
    captureFrame(-1, 16'h0000);
    checkFrame("h0F00", 16'hFBDE, 32'hFFBFC0C0);

    // Mid-frame change at slot 1 must not tear the current frame.
    applyStimulus(16'h1111, 4'b0000, 1'b0);
    waitFrameDone("h1111");
    captureFrame(RD, 16'h9999);
    checkFrame("h1111", 16'h7BDE, 32'hF9F9F9F9);
    captureFrame(-1, 16'h0000);
    checkFrame("h9999", 16'h7BDE, 32'h90909090);

    // Reset at idx=2, cnt=5 takes effect before the next clock edge.
    repeat (21) @(negedge clk);
    checkOutput("preRst_en", {4'b0, seven_segment_enable}, 8'h0B);
    checkOutput("preRst_data", seven_segment_data, 8'h90);
    reset = 1'b1;
    #1;
    checkOutput("asyncRst_en", {4'b0, seven_segment_enable}, 8'h0F);
    checkOutput("asyncRst_data", seven_segment_data, 8'hFF);
    checkOutput("asyncRst_fd", {7'b0, frame_done}, 8'h00);
    runResetFrame("rst1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
